// File: rtl/idelay_ctrl_mc.sv
// rtl/idelay_ctrl_mc.sv - multi-channel delay-tap controller with activity watchdog
// Taps only move while calibrated; a stalled reference drops RDY until it resumes and recalibrates.
module idelay_ctrl_mc #(
   parameter int NUM_CH     = 4,
   parameter int TAP_W      = 5,
   parameter int MAX_TAP    = 31,
   parameter int INIT_TAP   = 0,
   parameter int CAL_CYCLES = 64,
   parameter int TIMEOUT    = 16
) (
   input  logic                      refclk_in,
   input  logic                      rst_n,
   input  logic                      cal_rst,
   input  logic                      alive,
   input  logic [NUM_CH-1:0]         ce,
   input  logic [NUM_CH-1:0]         inc,
   input  logic [NUM_CH-1:0]         ld,
   input  logic [NUM_CH*TAP_W-1:0]   ld_val,
   output logic                      rdy,
   output logic [NUM_CH*TAP_W-1:0]   tap,
   output logic [NUM_CH-1:0]         sat,
   output logic [7:0]                lost_cnt
);

   localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int CAL_W = (CAL_CYCLES > 2) ? $clog2(CAL_CYCLES) : 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_CYCLES - 1);
   localparam logic [TAP_W-1:0] MAX_T    = TAP_W'(MAX_TAP);
   localparam logic [TAP_W-1:0] INIT_T   = TAP_W'(INIT_TAP);

   typedef enum logic [1:0] {ST_CAL, ST_READY, ST_LOST} state_t;

   state_t             state, state_n;
   logic               alive_q;
   logic [WD_W-1:0]    wd_cnt, wd_n;
   logic [CAL_W-1:0]   cal_cnt, cal_n;
   logic [TAP_W-1:0]   tap_q [NUM_CH];
   logic [TAP_W-1:0]   tap_n [NUM_CH];
   logic [NUM_CH-1:0]  sat_n;
   logic               tog, expiry, cmd_en, enter_lost;

   assign tog        = alive ^ alive_q;
   assign expiry     = !tog && (wd_cnt == WD_LAST);
   assign cmd_en     = (state == ST_READY) && !cal_rst;
   assign enter_lost = (state_n == ST_LOST) && (state != ST_LOST);
   assign rdy        = (state == ST_READY);

   always_comb begin
      state_n = state;
      cal_n   = cal_cnt;
      // Watchdog parks at its last value so a long stall in LOST cannot wrap it.
      wd_n    = tog ? '0 : ((wd_cnt == WD_LAST) ? wd_cnt : wd_cnt + WD_W'(1));
      if (cal_rst) begin
         state_n = ST_CAL;
         cal_n   = '0;
         wd_n    = '0;
      end else begin
         case (state)
            ST_CAL: begin
               if (expiry) begin
                  state_n = ST_LOST;
                  cal_n   = '0;
               end else if (cal_cnt == CAL_LAST) begin
                  state_n = ST_READY;
                  cal_n   = '0;
               end else begin
                  cal_n = cal_cnt + CAL_W'(1);
               end
            end
            ST_READY: if (expiry) state_n = ST_LOST;
            ST_LOST: begin
               if (tog) begin
                  state_n = ST_CAL;
                  cal_n   = '0;
               end
            end
            default: state_n = ST_CAL;
         endcase
      end
   end

   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         tap_n[ch] = tap_q[ch];
         sat_n[ch] = 1'b0;
         if (cal_rst) begin
            tap_n[ch] = INIT_T;
         end else if (cmd_en) begin
            if (ld[ch]) begin
               if (ld_val[ch*TAP_W +: TAP_W] > MAX_T) begin
                  tap_n[ch] = MAX_T;
                  sat_n[ch] = 1'b1;
               end else begin
                  tap_n[ch] = ld_val[ch*TAP_W +: TAP_W];
               end
            end else if (ce[ch]) begin
               if (inc[ch]) begin
                  if (tap_q[ch] == MAX_T) sat_n[ch] = 1'b1;
                  else                    tap_n[ch] = tap_q[ch] + TAP_W'(1);
               end else begin
                  if (tap_q[ch] == '0) sat_n[ch] = 1'b1;
                  else                 tap_n[ch] = tap_q[ch] - TAP_W'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge refclk_in or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_CAL;
         alive_q  <= 1'b0;
         wd_cnt   <= '0;
         cal_cnt  <= '0;
         sat      <= '0;
         lost_cnt <= 8'd0;
         for (int ch = 0; ch < NUM_CH; ch++) tap_q[ch] <= INIT_T;
      end else begin
         state   <= state_n;
         alive_q <= alive;
         wd_cnt  <= wd_n;
         cal_cnt <= cal_n;
         sat     <= sat_n;
         if (enter_lost && (lost_cnt != 8'hFF)) lost_cnt <= lost_cnt + 8'd1;
         for (int ch = 0; ch < NUM_CH; ch++) tap_q[ch] <= tap_n[ch];
      end
   end

   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++) tap[ch*TAP_W +: TAP_W] = tap_q[ch];
   end

endmodule
